// File: rtl/kernel_product.sv
// Element-wise fp32 multiply of two 49-lane kernels for the bilateral filter.
// Three data stages (unpack/multiply, normalise/round, special/pack) feed a held output register.
module kernel_product #(
  parameter int N_ELEM = 49
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] kernel_a [N_ELEM-1:0],
  input  logic [31:0] kernel_b [N_ELEM-1:0],
  input  logic        kernel_valid,
  output logic [31:0] product [N_ELEM-1:0],
  output logic        product_valid
);

  localparam int LATENCY = 3;

  typedef struct packed {
    logic               sign;
    logic signed [9:0]  exp;
    logic [47:0]        mant;
    logic               nan;
    logic               inf;
    logic               zero;
  } s1_t;

  typedef struct packed {
    logic               sign;
    logic signed [9:0]  exp;
    logic [22:0]        frac;
    logic               nan;
    logic               inf;
    logic               zero;
  } s2_t;

  function automatic s1_t unpack_mul(input logic [31:0] a, input logic [31:0] b);
    s1_t        r;
    logic [7:0] ea, eb;
    logic       a_inf, b_inf, a_nan, b_nan, a_zero, b_zero;
    ea     = a[30:23];
    eb     = b[30:23];
    a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    r.sign = a[31] ^ b[31];
    r.exp  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    r.mant = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    r.nan  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    r.inf  = a_inf || b_inf;
    r.zero = a_zero || b_zero;
    return r;
  endfunction

  // Round to nearest even; a carry out of the fraction renormalises to 1.0 x 2^(e+1).
  function automatic s2_t norm_round(input s1_t s);
    s2_t               r;
    logic signed [9:0] e;
    logic [22:0]       frac;
    logic              g, rd, st;
    logic [23:0]       sum;
    e = s.exp;
    if (s.mant[47]) begin
      frac = s.mant[46:24];
      g    = s.mant[23];
      rd   = s.mant[22];
      st   = |s.mant[21:0];
      e    = e + 10'sd1;
    end else begin
      frac = s.mant[45:23];
      g    = s.mant[22];
      rd   = s.mant[21];
      st   = |s.mant[20:0];
    end
    sum = {1'b0, frac} + {23'd0, g & (rd | st | frac[0])};
    if (sum[23]) e = e + 10'sd1;
    r.sign = s.sign;
    r.exp  = e;
    r.frac = sum[22:0];
    r.nan  = s.nan;
    r.inf  = s.inf;
    r.zero = s.zero;
    return r;
  endfunction

  function automatic logic [31:0] pack_result(input s2_t s);
    logic signed [9:0] e;
    e = s.exp;
    if (s.nan)              return 32'h7FC0_0000;
    else if (s.inf)         return {s.sign, 8'hFF, 23'd0};
    else if (s.zero)        return {s.sign, 31'd0};
    else if (e >= 10'sd255) return {s.sign, 8'hFF, 23'd0};
    else if (e <= 10'sd0)   return {s.sign, 31'd0};
    else                    return {s.sign, e[7:0], s.frac};
  endfunction

  s1_t                 s1_d [N_ELEM-1:0];
  s1_t                 s1_q [N_ELEM-1:0];
  s2_t                 s2_d [N_ELEM-1:0];
  s2_t                 s2_q [N_ELEM-1:0];
  logic [31:0]         s3_d [N_ELEM-1:0];
  logic [31:0]         s3_q [N_ELEM-1:0];
  logic [31:0]         product_q [N_ELEM-1:0];
  logic [LATENCY-1:0]  vld_q;
  logic                product_valid_q;

  always_comb begin
    for (int i = 0; i < N_ELEM; i++) begin
      s1_d[i] = unpack_mul(kernel_a[i], kernel_b[i]);
      s2_d[i] = norm_round(s1_q[i]);
      s3_d[i] = pack_result(s2_q[i]);
    end
  end

  // Data stages p1..p3: free-running, no reset
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
    s2_q <= s2_d;
    s3_q <= s3_d;
  end

  // Output stage: product holds between valid results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q           <= '0;
      product_valid_q <= 1'b0;
      for (int i = 0; i < N_ELEM; i++) product_q[i] <= 32'd0;
    end else begin
      vld_q           <= {vld_q[LATENCY-2:0], kernel_valid};
      product_valid_q <= vld_q[LATENCY-1];
      if (vld_q[LATENCY-1]) begin
        for (int i = 0; i < N_ELEM; i++) product_q[i] <= s3_q[i];
      end
    end
  end

  assign product       = product_q;
  assign product_valid = product_valid_q;

endmodule

// File: tb/tb_kernel_product.sv
// Bench for kernel_product: directed vectors plus randomized lanes against a real-arithmetic model.
module tb_kernel_product;

  localparam int N = 49;

  typedef struct packed {
    logic                v;
    logic [N-1:0][31:0]  r;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] ka [N-1:0];
  logic [31:0] kb [N-1:0];
  logic        kv;
  logic [31:0] prod [N-1:0];
  logic        pv;

  int checks = 0;
  int fails  = 0;

  ent_t               q[$];
  logic [N-1:0][31:0] exp_p;
  logic               exp_v;

  kernel_product dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .kernel_a      (ka),
    .kernel_b      (kb),
    .kernel_valid  (kv),
    .product       (prod),
    .product_valid (pv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact product in double precision, then a single RNE rounding to fp32.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s, a_nan, b_nan, a_inf, b_inf;
    logic [7:0]  ea, eb;
    real         va, vb, p;
    logic [63:0] d;
    int          e;
    logic [22:0] m;
    logic        g, st;
    logic [23:0] sum;
    s  = a[31] ^ b[31];
    ea = a[30:23];
    eb = b[30:23];
    a_nan = (ea == 8'hFF) && (a[22:0] != 0);
    b_nan = (eb == 8'hFF) && (b[22:0] != 0);
    a_inf = (ea == 8'hFF) && (a[22:0] == 0);
    b_inf = (eb == 8'hFF) && (b[22:0] == 0);
    if (a_nan || b_nan || (a_inf && eb == 0) || (b_inf && ea == 0)) return 32'h7FC00000;
    if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
    if (ea == 0 || eb == 0) return {s, 31'd0};
    va  = $bitstoreal({1'b0, 11'(int'(ea) + 896), a[22:0], 29'd0});
    vb  = $bitstoreal({1'b0, 11'(int'(eb) + 896), b[22:0], 29'd0});
    p   = va * vb;
    d   = $realtobits(p);
    e   = int'(d[62:52]) - 1023 + 127;
    m   = d[51:29];
    g   = d[28];
    st  = |d[27:0];
    sum = {1'b0, m} + 24'(g && (st || m[0]));
    if (sum[23]) e = e + 1;
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), sum[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int          k;
    v = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0:       return {v[31], 31'd0};
      1:       return {v[31], 8'd0, v[22:0]};
      2:       return {v[31], 8'hFF, 23'd0};
      3:       return {v[31], 8'hFF, v[22:1], 1'b1};
      4:       return {v[31], 8'($urandom_range(190, 254)), v[22:0]};
      5:       return {v[31], 8'($urandom_range(1, 50)), v[22:0]};
      default: return {v[31], 8'($urandom_range(100, 154)), v[22:0]};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  task automatic chk_lanes(input string tag);
    int bad;
    bad = 0;
    for (int i = N - 1; i >= 0; i--) if (prod[i] !== exp_p[i]) bad = i;
    chk($sformatf("%s_lane%0d", tag, bad), prod[bad], exp_p[bad]);
  endtask

  task automatic cycle(input string tag);
    ent_t e;
    e.v = kv;
    for (int i = 0; i < N; i++) e.r[i] = ref_mul(ka[i], kb[i]);
    @(posedge clk);
    exp_v = 1'b0;
    if (rst_n) begin
      q.push_back(e);
      if (q.size() == 4) begin
        e = q.pop_front();
        exp_v = e.v;
        if (e.v) exp_p = e.r;
      end
    end
    #1;
    chk({tag, "_valid"}, {31'd0, pv}, {31'd0, exp_v});
    chk_lanes(tag);
  endtask

  task automatic set_all(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < N; i++) begin
      ka[i] = a;
      kb[i] = b;
    end
  endtask

  task automatic set_rand();
    for (int i = 0; i < N; i++) begin
      ka[i] = rand_fp();
      kb[i] = rand_fp();
    end
  endtask

  logic [31:0] tbl_a [9] = '{32'h40000000, 32'h3F000000, 32'hBFC00000, 32'h7F000000, 32'h00800000,
                             32'h7F800000, 32'h80000000, 32'h3F800001, 32'h3FFFFFFF};
  logic [31:0] tbl_b [9] = '{32'h40400000, 32'h3F000000, 32'h40000000, 32'h40000000, 32'h3F000000,
                             32'h00000000, 32'h3F800000, 32'h3F800001, 32'h3FFFFFFF};
  logic [31:0] tbl_e [9] = '{32'h40C00000, 32'h3E800000, 32'hC0400000, 32'h7F800000, 32'h00000000,
                             32'h7FC00000, 32'h80000000, 32'h3F800002, 32'h407FFFFE};
  logic        pat [22] = '{1,0,1,0,1,0,1,0,1,0, 1,1,1,1,0,1,1,0, 0,0,0,0};

  initial begin
    rst_n = 1'b0;
    kv    = 1'b0;
    exp_v = 1'b0;
    exp_p = '0;
    set_all(32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, pv}, 32'd0);
    chk_lanes("reset_prod");
    rst_n = 1'b1;

    // Identity with exact latency
    set_all(32'h3D14FA29, 32'h3F800000);
    kv = 1'b1;
    cycle("ident_t0");
    kv = 1'b0;
    cycle("ident_t1");
    cycle("ident_t2");
    chk("ident_early_valid", {31'd0, pv}, 32'd0);
    cycle("ident_t3");
    chk("ident_valid_t3", {31'd0, pv}, 32'd1);
    chk("ident_lane16", prod[16], 32'h3D14FA29);
    cycle("ident_t4");
    chk("ident_pulse_end", {31'd0, pv}, 32'd0);
    chk("ident_hold16", prod[16], 32'h3D14FA29);

    // Directed arithmetic, special and rounding vectors
    for (int k = 0; k < 9; k++) begin
      set_all(tbl_a[k], tbl_b[k]);
      kv = 1'b1;
      cycle("vec_in");
      kv = 1'b0;
      repeat (3) cycle("vec_wait");
      chk($sformatf("vec%0d_lane7", k), prod[7], tbl_e[k]);
    end

    // Alternating valid and bursts with fresh random data every cycle
    foreach (pat[k]) begin
      set_rand();
      kv = pat[k];
      cycle("pat");
    end
    for (int k = 0; k < 40; k++) begin
      set_rand();
      kv = ($urandom_range(0, 2) != 0);
      cycle("rnd");
    end
    kv = 1'b0;
    repeat (4) cycle("drain");

    // Reset with two valids in flight
    set_rand();
    kv = 1'b1;
    cycle("rst_in0");
    set_rand();
    cycle("rst_in1");
    kv = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {31'd0, pv}, 32'd0);
    q.delete();
    exp_p = '0;
    exp_v = 1'b0;
    chk_lanes("rst_async_prod");
    cycle("rst_hold");
    #2;
    rst_n = 1'b1;
    repeat (6) cycle("rst_after");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
